// File: rtl/sia_pkg.sv
// Shared definitions for the Serial Interface Adapter (sia_uart):
// register offsets, STATUS bit positions and the TX/RX state encoding.
package sia_pkg;

    // Register offsets on adr_i
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;
    localparam logic [1:0] REG_IRQEN  = 2'd3;

    // STATUS bit positions
    localparam int ST_RX_AVAIL  = 0;
    localparam int ST_TX_SPACE  = 1;
    localparam int ST_TX_IDLE   = 2;
    localparam int ST_RX_OVF    = 3;
    localparam int ST_FRAME_ERR = 4;
    localparam int ST_TX_OVF    = 5;

    // IRQEN bit positions
    localparam int IE_RX_AVAIL = 0;
    localparam int IE_TX_IDLE  = 1;
    localparam int IE_ERR      = 2;

    // Frame phase shared by the transmitter and the receiver
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } sia_state_e;

endpackage

// File: rtl/sia_fifo.sv
// Byte-wide synchronous FIFO, 2**LOG2 entries, show-ahead read port.
// Push and pop together are accepted at any fill level; a pop on an
// empty FIFO is ignored, and a push into a full FIFO only succeeds when
// a pop frees a slot in the same cycle.
module sia_fifo
    import sia_pkg::*;
#(
    parameter int LOG2 = 4
) (
    input  logic       clk_i,
    input  logic       reset_in,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int              DEPTH    = 1 << LOG2;
    localparam logic [LOG2:0]   FULL_CNT = (LOG2 + 1)'(DEPTH);

    logic [7:0]      mem [DEPTH];
    logic [LOG2-1:0] wr_ptr;
    logic [LOG2-1:0] rd_ptr;
    logic [LOG2:0]   count;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge clk_i or negedge reset_in) begin
        if (!reset_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + LOG2'(1);
            if (do_pop)  rd_ptr <= rd_ptr + LOG2'(1);
            count <= count + (LOG2 + 1)'(do_push) - (LOG2 + 1)'(do_pop);
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/sia_uart.sv
// Serial Interface Adapter: 16-bit Wishbone slave with one 8N1 UART,
// 16-entry TX and RX FIFOs, programmable bit divisor, sticky error
// flags and a level interrupt.
module sia_uart
    import sia_pkg::*;
#(
    parameter logic [15:0] DEFAULT_DIV = 16'd217,
    parameter int          FIFO_LOG2   = 4
) (
    input  logic        clk_i,
    input  logic        reset_in,
    input  logic [1:0]  adr_i,
    input  logic [15:0] dat_i,
    input  logic [1:0]  sel_i,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    output logic        ack_o,
    output logic [15:0] dat_o,
    output logic        txd_o,
    input  logic        rxd_i,
    output logic        irq_o
);

    logic [15:0] divisor;
    logic [15:0] div_new;
    logic [2:0]  irq_en;
    logic        rx_ovf, frame_err, tx_ovf;
    logic [15:0] status;
    logic [15:0] rd_mux;

    logic        bus_wr, bus_rd;
    logic        tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0]  tx_dout;
    logic        rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]  rx_dout;

    sia_state_e  tx_state;
    logic [15:0] tx_cnt;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_shift;
    logic        tx_load, tx_idle;

    sia_state_e  rx_state;
    logic [15:0] rx_cnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shift;
    logic        rx_meta, rx_s, rx_brk;
    logic        rx_done, frame_set, rx_ovf_set, tx_ovf_set, status_clr;

    // Side effects only happen in the ack cycle, when the bus is still held
    assign bus_wr     = ack_o & we_i;
    assign bus_rd     = ack_o & ~we_i;
    assign tx_push    = bus_wr & (adr_i == REG_DATA) & sel_i[0];
    assign rx_pop     = bus_rd & (adr_i == REG_DATA) & ~rx_empty;
    assign status_clr = bus_rd & (adr_i == REG_STATUS);

    // A pop that coincides with a push into a full FIFO makes room, so no overflow
    assign tx_ovf_set = tx_push & tx_full & ~tx_pop;
    assign rx_ovf_set = rx_push & rx_full & ~rx_pop;

    sia_fifo #(.LOG2(FIFO_LOG2)) u_tx_fifo (
        .clk_i   (clk_i),
        .reset_in(reset_in),
        .push    (tx_push),
        .pop     (tx_pop),
        .din     (dat_i[7:0]),
        .dout    (tx_dout),
        .full    (tx_full),
        .empty   (tx_empty)
    );

    sia_fifo #(.LOG2(FIFO_LOG2)) u_rx_fifo (
        .clk_i   (clk_i),
        .reset_in(reset_in),
        .push    (rx_push),
        .pop     (rx_pop),
        .din     (rx_shift),
        .dout    (rx_dout),
        .full    (rx_full),
        .empty   (rx_empty)
    );

    // Registered acknowledge: one wait state, held strobe acked every other cycle
    always_ff @(posedge clk_i or negedge reset_in) begin
        if (!reset_in) ack_o <= 1'b0;
        else           ack_o <= cyc_i & stb_i & ~ack_o;
    end

    // Byte-lane merge of a DIVISOR write; values below 2 are clamped to 2
    always_comb begin
        div_new = {sel_i[1] ? dat_i[15:8] : divisor[15:8],
                   sel_i[0] ? dat_i[7:0]  : divisor[7:0]};
        if (div_new < 16'd2) div_new = 16'd2;
    end

    // Writable configuration registers
    always_ff @(posedge clk_i or negedge reset_in) begin
        if (!reset_in) begin
            divisor <= DEFAULT_DIV;
            irq_en  <= '0;
        end else if (bus_wr) begin
            if (adr_i == REG_DIV) divisor <= div_new;
            if (adr_i == REG_IRQEN && sel_i[0]) irq_en <= dat_i[2:0];
        end
    end

    // Sticky flags: a STATUS read clears them, but a same-cycle set wins
    always_ff @(posedge clk_i or negedge reset_in) begin
        if (!reset_in) begin
            rx_ovf    <= 1'b0;
            frame_err <= 1'b0;
            tx_ovf    <= 1'b0;
        end else begin
            rx_ovf    <= rx_ovf_set | (rx_ovf & ~status_clr);
            frame_err <= frame_set  | (frame_err & ~status_clr);
            tx_ovf    <= tx_ovf_set | (tx_ovf & ~status_clr);
        end
    end

    // STATUS word and read-data mux; dat_o is forced to 0 outside read acks
    always_comb begin
        status               = '0;
        status[ST_RX_AVAIL]  = ~rx_empty;
        status[ST_TX_SPACE]  = ~tx_full;
        status[ST_TX_IDLE]   = tx_idle;
        status[ST_RX_OVF]    = rx_ovf;
        status[ST_FRAME_ERR] = frame_err;
        status[ST_TX_OVF]    = tx_ovf;
        case (adr_i)
            REG_DATA:   rd_mux = {8'h00, rx_empty ? 8'h00 : rx_dout};
            REG_STATUS: rd_mux = status;
            REG_DIV:    rd_mux = divisor;
            default:    rd_mux = {13'd0, irq_en};
        endcase
    end

    assign dat_o = bus_rd ? rd_mux : 16'h0000;

    // Level interrupt, one register of latency
    always_ff @(posedge clk_i or negedge reset_in) begin
        if (!reset_in) irq_o <= 1'b0;
        else irq_o <= (irq_en[IE_RX_AVAIL] & ~rx_empty)
                    | (irq_en[IE_TX_IDLE]  & tx_idle)
                    | (irq_en[IE_ERR]      & (rx_ovf | frame_err | tx_ovf));
    end

    // ---------------- Transmitter ----------------
    // A byte is loaded from IDLE, or straight from the last STOP clock so
    // queued bytes go out back-to-back
    assign tx_load = ~tx_empty & ((tx_state == IDLE) ||
                                  (tx_state == STOP && tx_cnt == 16'd0));
    assign tx_pop  = tx_load;
    assign tx_idle = tx_empty & (tx_state == IDLE);
    assign txd_o   = (tx_state == START) ? 1'b0 :
                     (tx_state == DATA)  ? tx_shift[0] : 1'b1;

    // TX phase sequencing; each phase/bit lasts divisor clocks
    always_ff @(posedge clk_i or negedge reset_in) begin
        if (!reset_in) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
        end else if (tx_load) begin
            tx_state <= START;
            tx_cnt   <= divisor - 16'd1;
        end else if (tx_state != IDLE) begin
            if (tx_cnt != 16'd0) begin
                tx_cnt <= tx_cnt - 16'd1;
            end else begin
                tx_cnt <= divisor - 16'd1;
                case (tx_state)
                    START: begin
                        tx_state <= DATA;
                        tx_bit   <= '0;
                    end
                    DATA: begin
                        if (tx_bit == 3'd7) tx_state <= STOP;
                        else                tx_bit   <= tx_bit + 3'd1;
                    end
                    default: tx_state <= IDLE;
                endcase
            end
        end
    end

    // TX shift register, LSB first
    always_ff @(posedge clk_i) begin
        if (tx_load)                                  tx_shift <= tx_dout;
        else if (tx_state == DATA && tx_cnt == 16'd0) tx_shift <= {1'b0, tx_shift[7:1]};
    end

    // ---------------- Receiver ----------------
    // Two-flop synchronizer for the asynchronous serial input
    always_ff @(posedge clk_i or negedge reset_in) begin
        if (!reset_in) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rxd_i;
            rx_s    <= rx_meta;
        end
    end

    assign rx_done   = (rx_state == STOP) && (rx_cnt == 16'd0);
    assign rx_push   = rx_done & rx_s;
    assign frame_set = rx_done & ~rx_s;

    // RX phase sequencing. IDLE is only entered with the line high (or with
    // rx_brk waiting for it), so a low level in IDLE is a falling edge.
    always_ff @(posedge clk_i or negedge reset_in) begin
        if (!reset_in) begin
            rx_state <= IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_brk   <= 1'b0;
        end else if (rx_state == IDLE) begin
            if (rx_brk) begin
                if (rx_s) rx_brk <= 1'b0;
            end else if (!rx_s) begin
                rx_state <= START;
                rx_cnt   <= {1'b0, divisor[15:1]} - 16'd1;
            end
        end else if (rx_cnt != 16'd0) begin
            rx_cnt <= rx_cnt - 16'd1;
        end else begin
            rx_cnt <= divisor - 16'd1;
            case (rx_state)
                START: begin
                    if (rx_s) begin
                        rx_state <= IDLE;
                    end else begin
                        rx_state <= DATA;
                        rx_bit   <= '0;
                    end
                end
                DATA: begin
                    if (rx_bit == 3'd7) rx_state <= STOP;
                    else                rx_bit   <= rx_bit + 3'd1;
                end
                default: begin
                    rx_state <= IDLE;
                    if (!rx_s) rx_brk <= 1'b1;
                end
            endcase
        end
    end

    // RX shift register, LSB arrives first
    always_ff @(posedge clk_i) begin
        if (rx_state == DATA && rx_cnt == 16'd0) rx_shift <= {rx_s, rx_shift[7:1]};
    end

endmodule
